line_responder: RTL and testbench
=================================

Name: line_responder

Overview:
- Command-processing back end for the keyboard/VGA line console.
- The I/O controller assembles a typed line in `buff`/`buff_len` and raises `finish`. This block latches the line, executes a one-letter command, and builds the reply string in `result`/`result_len`.
- It raises `ready`. The I/O controller then streams `result` to the display.

Parameters:
- MAX_CHARS, 64, maximum line length in characters (`buff` width = 8*MAX_CHARS).
- RES_CHARS, 128, reply capacity in characters (`result` width = 8*RES_CHARS).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- finish  input  1  line-complete flag from the I/O controller; may originate on another clock domain.
- buff  input  512  line characters; char i at `buff[8i+:8]`; held stable from `finish` until the next line starts.
- buff_len  input  64  line length in BITS (8 per char).
- result  output  1024  reply characters; char j at `result[8j+:8]`.
- result_len  output  8  reply length in characters.
- ready  output  1  reply valid; level signal.
- busy  output  1  high in LATCH, PARSE and PROC.

Behaviour:
- Reset: `result`=0, `result_len`=0, `ready`=0, `busy`=0, state IDLE, both synchronizer flops 0. Reset is asynchronous and may occur mid-operation: everything returns to IDLE and any reply in progress is discarded.
- `finish` synchronization:
  - `finish` passes through a 2-flop synchronizer, then a rising-edge detector.
  - If `finish` is high when reset is released, it counts as a new edge.
  - Edges seen in LATCH/PARSE/PROC are ignored.
  - Edges seen in IDLE or DONE are accepted.
- Length derivation:
  - n = `buff_len[9:3]`.
  - If `buff_len` > 512, n = 64 (clip).
  - m = n-2 when n ≥ 2, else 0. m is the number of argument characters, i.e. `buff[16+:]` onward.
- FSM states:
  - IDLE: wait for an accepted edge, then go to LATCH.
  - LATCH (1 cycle):
    - Capture `buff` into an internal line register and capture n.
    - Clear `result`, `result_len`, `ready`.
    - Set `busy`=1.
  - PARSE (1 cycle):
    - c0 = char0, c1 = char1.
    - Command is valid only if n ≥ 2, c1 = 0x20, and c0 ∈ {'E','R','U','L'}.
    - Sets P (the number of PROC cycles):
      - For E/R/U, P = max(m,1).
      - Otherwise P = 1.
    - Then go to PROC.
  - PROC (P cycles). Per command:
    - E, echo: `result[k]` = char[2+k].
    - R, reverse: `result[k]` = char[n-1-k].
    - U, upper-case: `result[k]` = char[2+k], minus 0x20 if in 0x61..0x7A.
    - Index k runs 0..m-1, one character per cycle. `result_len` = m.
    - If m = 0, the single PROC cycle writes nothing.
    - L, length: one cycle. `result[0]` = '0'+m/10, `result[1]` = '0'+m%10, `result_len` = 2.
    - n = 0 (empty line): `result_len` = 0.
    - Any other invalid line: `result` = "ERR" (0x45,0x52,0x52), `result_len` = 3.
  - DONE:
    - `ready`=1, `busy`=0. `result` and `result_len` are held stable.
    - An accepted edge goes to LATCH; `ready` drops at that LATCH edge.
- Latency:
  - Edge 0 is the first clk edge that samples `finish`=1.
  - LATCH occurs at edge 2 and PARSE at edge 3.
  - PROC covers edges 4..3+P.
  - `ready` is high after edge 4+P.
- `result_len` never exceeds 62. Bytes of `result` beyond `result_len` are 0.
- `buff` contents beyond n characters are ignored.

Test Plan:
- "E hi" (n=4), `finish` pulse → `result[15:0]` = 0x6968, `result_len`=2, `ready` after edge 6, `busy` high edges 2-5.
- "R abc" → `result[23:0]` = 0x616263 ("cba"), `result_len`=3, `ready` after edge 7.
- "U aZ9!" → "AZ9!" (0x21395A41), `result_len`=4; non-letters unchanged.
- "L hello" → "05" (0x3530), `result_len`=2. "X yz" → "ERR", len 3. `buff_len`=0 → `result_len`=0, `ready`=1 after edge 5.
- "E " + 62×'a', `buff_len`=512 → `result_len`=62, `ready` after edge 66. Repeat with `buff_len`=600 → identical result (clip).
- Second `finish` edge during PROC → ignored. Then `rst_n` low during a later PROC → `ready`/`result`/`result_len` = 0 immediately. `finish` held high through reset release → processed as a new line.

Source files
------------

// File: rtl/line_responder.sv
// Command back end for the line console: latches a typed line, runs a one-letter
// command (E/R/U/L) and builds the reply string for the I/O controller to display.
module line_responder #(
    parameter int MAX_CHARS = 64,
    parameter int RES_CHARS = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   finish,
    input  logic [8*MAX_CHARS-1:0] buff,
    input  logic [63:0]            buff_len,
    output logic [8*RES_CHARS-1:0] result,
    output logic [7:0]             result_len,
    output logic                   ready,
    output logic                   busy
);

    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam int IW = $clog2(MAX_CHARS);
    localparam int RW = $clog2(RES_CHARS);

    typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_PARSE, ST_PROC, ST_DONE} state_t;
    typedef enum logic [2:0] {CMD_NONE, CMD_ECHO, CMD_REV, CMD_UP, CMD_LEN, CMD_ERR} cmd_t;

    state_t                 state_r;
    cmd_t                   cmd_r;
    cmd_t                   cmd_s;
    logic                   finish_meta_r;
    logic                   finish_sync_r;
    logic                   finish_prev_r;
    logic                   rise_s;
    logic [8*MAX_CHARS-1:0] line_r;
    logic [CW-1:0]          n_r;
    logic [CW-1:0]          m_r;
    logic [CW-1:0]          p_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          n_s;
    logic [CW-1:0]          m_s;
    logic [CW-1:0]          p_s;
    logic [IW-1:0]          src_idx_s;
    logic [7:0]             src_byte_s;
    logic [7:0]             proc_byte_s;
    logic [7:0]             tens_s;
    logic [7:0]             ones_s;
    logic [8*RES_CHARS-1:0] result_r;
    logic [7:0]             result_len_r;
    logic                   ready_r;
    logic                   busy_r;

    assign rise_s     = finish_sync_r & ~finish_prev_r;
    assign result     = result_r;
    assign result_len = result_len_r;
    assign ready      = ready_r;
    assign busy       = busy_r;

    // Character count from the bit length, clipped to the line capacity.
    always_comb begin
        n_s = '0;
        m_s = '0;
        if (buff_len > 64'(8 * MAX_CHARS)) begin
            n_s = CW'(MAX_CHARS);
        end else begin
            n_s = buff_len[CW+2:3];
        end
        if (n_s >= CW'(2)) begin
            m_s = n_s - CW'(2);
        end else begin
            m_s = '0;
        end
    end

    // Command decode of the latched line and the number of processing cycles.
    always_comb begin
        cmd_s = CMD_ERR;
        p_s   = CW'(1);
        if (n_r == '0) begin
            cmd_s = CMD_NONE;
        end else if ((n_r >= CW'(2)) && (line_r[15:8] == 8'h20)) begin
            case (line_r[7:0])
                8'h45:   cmd_s = CMD_ECHO;
                8'h52:   cmd_s = CMD_REV;
                8'h55:   cmd_s = CMD_UP;
                8'h4C:   cmd_s = CMD_LEN;
                default: cmd_s = CMD_ERR;
            endcase
        end else begin
            cmd_s = CMD_ERR;
        end
        if (((cmd_s == CMD_ECHO) || (cmd_s == CMD_REV) || (cmd_s == CMD_UP)) && (m_r != '0)) begin
            p_s = m_r;
        end else begin
            p_s = CW'(1);
        end
    end

    // Source character for the current output index, with optional upper-casing.
    always_comb begin
        src_idx_s   = '0;
        proc_byte_s = 8'h00;
        if (cmd_r == CMD_REV) begin
            src_idx_s = IW'(n_r - CW'(1) - cnt_r);
        end else begin
            src_idx_s = IW'(cnt_r + CW'(2));
        end
        src_byte_s = line_r[{src_idx_s, 3'b000} +: 8];
        if ((cmd_r == CMD_UP) && (src_byte_s >= 8'h61) && (src_byte_s <= 8'h7A)) begin
            proc_byte_s = src_byte_s - 8'h20;
        end else begin
            proc_byte_s = src_byte_s;
        end
        tens_s = 8'(m_r / CW'(10));
        ones_s = 8'(m_r % CW'(10));
    end

    // Finish synchronizer, edge history and the command FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_meta_r <= 1'b0;
            finish_sync_r <= 1'b0;
            finish_prev_r <= 1'b0;
            state_r       <= ST_IDLE;
            cmd_r         <= CMD_NONE;
            line_r        <= '0;
            n_r           <= '0;
            m_r           <= '0;
            p_r           <= '0;
            cnt_r         <= '0;
            result_r      <= '0;
            result_len_r  <= 8'h00;
            ready_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            finish_meta_r <= finish;
            finish_sync_r <= finish_meta_r;
            finish_prev_r <= finish_sync_r;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (rise_s) begin
                        line_r       <= buff;
                        n_r          <= n_s;
                        m_r          <= m_s;
                        result_r     <= '0;
                        result_len_r <= 8'h00;
                        ready_r      <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    cmd_r   <= cmd_s;
                    p_r     <= p_s;
                    cnt_r   <= '0;
                    state_r <= ST_PARSE;
                end
                ST_PARSE, ST_PROC: begin
                    if (cnt_r == p_r) begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ST_PROC;
                        case (cmd_r)
                            CMD_ECHO, CMD_REV, CMD_UP: begin
                                if (m_r != '0) begin
                                    result_r[{RW'(cnt_r), 3'b000} +: 8] <= proc_byte_s;
                                    result_len_r                       <= 8'(m_r);
                                end
                            end
                            CMD_LEN: begin
                                result_r[7:0]  <= 8'h30 + tens_s;
                                result_r[15:8] <= 8'h30 + ones_s;
                                result_len_r   <= 8'h02;
                            end
                            CMD_ERR: begin
                                result_r[23:0] <= 24'h525245;
                                result_len_r   <= 8'h03;
                            end
                            default: begin
                                result_len_r <= 8'h00;
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_responder.sv
// Bench for line_responder: directed lines checked against literal replies and
// against a per-cycle behavioural model of the reply protocol.
module tb_line_responder;

    logic          clk;
    logic          rst_n;
    logic          finish;
    logic [511:0]  buff;
    logic [63:0]   buff_len;
    logic [1023:0] result;
    logic [7:0]    result_len;
    logic          ready;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic          h1, h2, h3, acc;
    logic          m_busy, m_ready, m_latch;
    int            m_cnt, m_len, pend_len, pend_p;
    logic [1023:0] m_res, pend_res;

    line_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .finish     (finish),
        .buff       (buff),
        .buff_len   (buff_len),
        .result     (result),
        .result_len (result_len),
        .ready      (ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reply as the command rules define it, from the raw line and bit length.
    function automatic void model_line(input logic [511:0] b, input logic [63:0] bl,
                                       output logic [1023:0] res, output int len, output int p);
        logic [7:0] c [64];
        logic [7:0] ch;
        int n, m;
        for (int i = 0; i < 64; i++) c[i] = b[8*i +: 8];
        n   = (bl > 64'd512) ? 64 : int'(bl >> 3);
        m   = (n >= 2) ? n - 2 : 0;
        res = '0;
        len = 0;
        p   = 1;
        if (n == 0) begin
            len = 0;
        end else if (n >= 2 && c[1] == 8'h20 && c[0] == 8'h4C) begin
            res[7:0]  = 8'(48 + m / 10);
            res[15:8] = 8'(48 + m % 10);
            len       = 2;
        end else if (n >= 2 && c[1] == 8'h20 &&
                     (c[0] == 8'h45 || c[0] == 8'h52 || c[0] == 8'h55)) begin
            p   = (m == 0) ? 1 : m;
            len = m;
            for (int k = 0; k < m; k++) begin
                ch = (c[0] == 8'h52) ? c[n-1-k] : c[2+k];
                if (c[0] == 8'h55 && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
                res[8*k +: 8] = ch;
            end
        end else begin
            res[23:0] = 24'h525245;
            len       = 3;
        end
    endfunction

    // Protocol model: a finish rise is acted on two edges after it is first sampled.
    initial begin
        h1 = 0; h2 = 0; h3 = 0; m_busy = 0; m_ready = 0; m_latch = 0;
        m_cnt = 0; m_len = 0; m_res = '0; pend_res = '0; pend_len = 0; pend_p = 1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                h1 = 0; h2 = 0; h3 = 0; m_busy = 0; m_ready = 0; m_latch = 0;
                m_res = '0; m_len = 0; m_cnt = 0;
            end else begin
                acc = h2 && !h3;
                h3 = h2; h2 = h1; h1 = finish;
                m_latch = 0;
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 0; m_ready = 1; m_res = pend_res; m_len = pend_len;
                    end
                end else if (acc) begin
                    model_line(buff, buff_len, pend_res, pend_len, pend_p);
                    m_busy = 1; m_ready = 0; m_latch = 1; m_cnt = pend_p + 2;
                    m_res = '0; m_len = 0;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk(busy === m_busy, "busy", 64'(busy), 64'(m_busy));
            chk(ready === m_ready, "ready", 64'(ready), 64'(m_ready));
            if (!m_busy || m_latch) begin
                chk(result === m_res, "result", result[63:0], m_res[63:0]);
                chk(result_len === 8'(m_len), "result_len", 64'(result_len), 64'(m_len));
            end
        end
    end

    task automatic load(input string s, input int bits);
        for (int i = 0; i < 64; i++) buff[8*i +: 8] = (i < s.len()) ? s[i] : 8'h7A;
        buff_len = 64'(bits);
    endtask

    task automatic wait_ready(output int edges);
        edges = -1;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);
            if (ready === 1'b1 && e > 2) begin
                edges = e;
                break;
            end
        end
        if (edges < 0) chk(1'b0, "ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_line(input string s, input int bits, input int exp_edges,
                            input logic [31:0] exp_word, input int nbytes, input int exp_len);
        int got;
        logic [31:0] mask;
        @(negedge clk);
        load(s, bits);
        finish = 1'b1;
        wait_ready(got);
        mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        chk(got == exp_edges, {"edges '", s, "'"}, 64'(got), 64'(exp_edges));
        chk((result[31:0] & mask) == exp_word, {"word '", s, "'"}, 64'(result[31:0] & mask), 64'(exp_word));
        chk(result_len == 8'(exp_len), {"len '", s, "'"}, 64'(result_len), 64'(exp_len));
        finish = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        string s62;
        int got;
        rst_n = 1'b0; finish = 1'b0; buff = '0; buff_len = '0;
        repeat (3) @(negedge clk);
        #1;
        chk(result === '0, "reset_result", result[63:0], 64'd0);
        chk(result_len === 8'h00, "reset_len", 64'(result_len), 64'd0);
        chk(ready === 1'b0, "reset_ready", 64'(ready), 64'd0);
        chk(busy === 1'b0, "reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_line("E hi",    32, 6, 32'h0000_6968, 2, 2);
        run_line("R abc",   40, 7, 32'h0061_6263, 3, 3);
        run_line("U aZ9!",  48, 8, 32'h2139_5A41, 4, 4);
        run_line("L hello", 56, 5, 32'h0000_3530, 2, 2);
        run_line("X yz",    32, 5, 32'h0052_5245, 3, 3);
        run_line("",         0, 5, 32'h0000_0000, 4, 0);
        s62 = "E ";
        for (int i = 0; i < 62; i++) s62 = {s62, "a"};
        run_line(s62, 512, 66, 32'h6161_6161, 4, 62);
        run_line(s62, 600, 66, 32'h6161_6161, 4, 62);

        // second finish rise during PROC must be ignored
        @(negedge clk);
        load("E abcdefghijklmnopqrst", 176);
        finish = 1'b1;
        got = -1;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);
            if (e == 8) finish = 1'b0;
            if (e == 11) finish = 1'b1;
            if (ready === 1'b1 && e > 2) begin
                got = e;
                break;
            end
        end
        chk(got == 24, "ignored_edge_latency", 64'(got), 64'd24);
        repeat (8) @(negedge clk);
        chk(ready === 1'b1, "ignored_edge_ready", 64'(ready), 64'd1);
        chk(result_len === 8'd20, "ignored_edge_len", 64'(result_len), 64'd20);
        finish = 1'b0;
        repeat (4) @(negedge clk);

        // reset during PROC, finish held high through release
        @(negedge clk);
        load("E 0123456789", 96);
        finish = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(ready === 1'b0, "midreset_ready", 64'(ready), 64'd0);
        chk(busy === 1'b0, "midreset_busy", 64'(busy), 64'd0);
        chk(result_len === 8'h00, "midreset_len", 64'(result_len), 64'd0);
        chk(result === '0, "midreset_result", result[63:0], 64'd0);
        load("R xy", 32);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(got);
        chk(got == 6, "release_edges", 64'(got), 64'd6);
        chk(result[15:0] === 16'h7879, "release_word", 64'(result[15:0]), 64'h7879);
        chk(result_len === 8'h02, "release_len", 64'(result_len), 64'd2);
        finish = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
